aes_block_packer: RTL and testbench
===================================

Name: aes_block_packer

Overview:
- Upstream neighbour of the AES engine. Consumes the 32-bit HWPE source stream coming from the streamer and packs each group of four words into one 128-bit AES state block.
- Zero-pads a short final block on end-of-stream, counts emitted blocks, and decouples input from output with one assembly register plus one output register.
- Sustains 1 word/cycle when the engine does not back-pressure.

Parameters:
DATA_WIDTH, 32, input word width in bits
BLOCK_WIDTH, 128, AES block width; WORDS = BLOCK_WIDTH/DATA_WIDTH (must divide exactly, 4 by default)
CNT_WIDTH, 16, width of emitted-block counter

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous reset, active-high
clear_i  in  1  synchronous soft clear from controller, active-high
in_data_i  in  DATA_WIDTH  input word
in_last_i  in  1  marks final word of stream
in_valid_i  in  1  input valid
in_ready_o  out  1  input ready
blk_data_o  out  BLOCK_WIDTH  packed block
blk_last_o  out  1  block contains final stream word
blk_pad_o  out  1  block was zero-padded
blk_valid_o  out  1  block valid
blk_ready_i  in  1  block ready (engine)
blk_count_o  out  CNT_WIDTH  blocks handed off since reset/clear
busy_o  out  1  assembly or output register holds data

Behaviour:
- Reset/clear: synchronous. rst_i and clear_i are identical in effect, and clear_i has priority over every handshake in the same cycle. On either:
  - blk_valid_o=0, blk_last_o=0, blk_pad_o=0, blk_data_o=0, blk_count_o=0, busy_o=0.
  - Word index idx=0, state FILL, assembly register zeroed.
  - in_ready_o=0 while rst_i or clear_i is high.
  - Any block mid-assembly or held in the output register is discarded, with no output handshake.
- Handshakes: in and out follow valid/ready rules.
  - Transfer occurs when valid&&ready on the rising edge.
  - valid must not depend on ready.
  - Output data, last and pad are stable while blk_valid_o=1 and blk_ready_i=0.
- Word order: word k of a block (k = 0..WORDS-1, k = arrival order) lands in bits [k*DATA_WIDTH +: DATA_WIDTH].
- slot_free = !blk_valid_o || blk_ready_i.
- State FILL:
  - in_ready_o = (idx < WORDS-1) ? 1 : slot_free.
  - Accepted word with idx < WORDS-1 and !in_last_i: store the word, then idx++.
  - Accepted word with idx == WORDS-1: load the output register with the full block, blk_last_o=in_last_i, blk_pad_o=0; idx=0.
  - Accepted word with idx < WORDS-1 and in_last_i, slot_free=1: load the output register with the block, words idx+1..WORDS-1 zero; blk_last_o=1, blk_pad_o=1; idx=0.
  - Accepted word with idx < WORDS-1 and in_last_i, slot_free=0: store the word, go to FLUSH.
- State FLUSH:
  - in_ready_o=0.
  - When slot_free=1, emit the zero-padded block (last=1, pad=1), idx=0, go to FILL.
- Latency: a block is visible on blk_valid_o the cycle after its completing input handshake, or the cycle after slot_free in FLUSH.
- Output register:
  - Cleared (blk_valid_o=0) on an output handshake unless reloaded in the same cycle.
  - Simultaneous drain and load yields back-to-back blocks with no bubble.
- blk_count_o: increments by 1 per output handshake and wraps modulo 2^CNT_WIDTH.
- busy_o = (idx != 0) || (state == FLUSH) || blk_valid_o.
- Boundaries:
  - in_last_i on the first word (idx=0) produces a block with 3 zero words.
  - in_last_i exactly on word WORDS-1 produces no padding.
  - The next stream may begin in the cycle after last is accepted.

Optional Feature:
- Macro: AES_PACK_BYTESWAP_EN.
- Defined: each input word is byte-reversed before storage (in_data_i[7:0] goes to bits [31:24] of that word slot), matching FIPS-197 byte order for little-endian memory.
- Undefined: words are stored unchanged.
- Timing and handshakes are identical in both builds.

Decomposition:
- Shared package aes_package:
  - AES_BLOCK_WIDTH=128 and AES_WORD_WIDTH=32 constants.
  - typedef aes_block_t (logic [127:0]).
  - typedef enum pack_state_t {FILL, FLUSH}.
  - struct packer_flags_t {busy, blk_count}, for the controller flags.
- No sub-module. The optional byte-swap is a generate block, not a separate module.

Test Plan:
- Stream 0x03020100, 0x07060504, 0x0B0A0908, 0x0F0E0D0C (last on the 4th), blk_ready_i=1 -> one block 0x0F0E0D0C_0B0A0908_07060504_03020100 one cycle after the 4th handshake; last=1, pad=0, count=1.
- Two words 0x11111111, 0x22222222 (last on the 2nd), ready=1 -> block 0x0_0_22222222_11111111; last=1, pad=1.
- 8 words continuous, blk_ready_i held 0 until cycle 10 -> in_ready_o=0 on word 8 until the output drains; two blocks delivered in order, count=2, no word lost.
- Output stalled, single word 0xDEADBEEF with last -> enters FLUSH, in_ready_o=0; after ready=1, block with low word 0xDEADBEEF, upper 96 bits zero, pad=1.
- Two words accepted, then clear_i for 1 cycle -> busy_o=0, count=0, no block emitted; next 4 words form a clean block.
- Build with AES_PACK_BYTESWAP_EN, input word 0x03020100 -> stored as 0x00010203 in bits [31:0].

Source files
------------

// File: rtl/aes_package.sv
// Shared AES datapath types and constants used by the block packer and its neighbours.
package aes_package;

  localparam int unsigned AES_BLOCK_WIDTH = 128;
  localparam int unsigned AES_WORD_WIDTH  = 32;

  typedef logic [AES_BLOCK_WIDTH-1:0] aes_block_t;

  typedef enum logic {
    FILL  = 1'b0,
    FLUSH = 1'b1
  } pack_state_t;

  // Status exported to the controller.
  typedef struct packed {
    logic        busy;
    logic [15:0] blk_count;
  } packer_flags_t;

endpackage

// File: rtl/aes_block_packer.sv
// Packs DATA_WIDTH-bit stream words into BLOCK_WIDTH-bit AES blocks, zero-padding a short
// final block. One assembly register plus one output register.
// Optional macro AES_PACK_BYTESWAP_EN: byte-reverse each input word before storage.
module aes_block_packer
  import aes_package::*;
#(
  parameter int unsigned DATA_WIDTH  = AES_WORD_WIDTH,
  parameter int unsigned BLOCK_WIDTH = AES_BLOCK_WIDTH,
  parameter int unsigned CNT_WIDTH   = 16
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   clear_i,
  input  logic [DATA_WIDTH-1:0]  in_data_i,
  input  logic                   in_last_i,
  input  logic                   in_valid_i,
  output logic                   in_ready_o,
  output logic [BLOCK_WIDTH-1:0] blk_data_o,
  output logic                   blk_last_o,
  output logic                   blk_pad_o,
  output logic                   blk_valid_o,
  input  logic                   blk_ready_i,
  output logic [CNT_WIDTH-1:0]   blk_count_o,
  output logic                   busy_o
);

  localparam int unsigned WORDS = BLOCK_WIDTH / DATA_WIDTH;
  localparam int unsigned IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);

  pack_state_t            r_state, w_state_next;
  logic [IDX_W-1:0]       r_idx, w_idx_next;
  logic [BLOCK_WIDTH-1:0] r_asm, w_asm_next, w_asm_ins;
  logic [BLOCK_WIDTH-1:0] r_blk_data, w_blk_data_next;
  logic                   r_blk_valid, w_blk_valid_next;
  logic                   r_blk_last, w_blk_last_next;
  logic                   r_blk_pad, w_blk_pad_next;
  logic [CNT_WIDTH-1:0]   r_count, w_count_next;

  logic [DATA_WIDTH-1:0]  w_word;
  logic                   w_slot_free;
  logic                   w_in_fire;
  logic                   w_out_fire;

`ifdef AES_PACK_BYTESWAP_EN
  // Byte 0 of the input lands in the most significant byte of the word slot.
  for (genvar b = 0; b < DATA_WIDTH / 8; b++) begin : g_byteswap
    assign w_word[b*8 +: 8] = in_data_i[DATA_WIDTH-8-b*8 +: 8];
  end
`else
  assign w_word = in_data_i;
`endif

  assign w_slot_free = !r_blk_valid || blk_ready_i;
  assign in_ready_o  = !rst_i && !clear_i && (r_state == FILL) &&
                       ((r_idx != LAST_IDX) || w_slot_free);
  assign w_in_fire   = in_valid_i && in_ready_o;
  // Clear wins over the output handshake, so a discarded block is never counted.
  assign w_out_fire  = r_blk_valid && blk_ready_i && !clear_i;

  // Assembly contents with the incoming word placed in the current slot.
  always_comb begin
    w_asm_ins = r_asm;
    for (int unsigned k = 0; k < WORDS; k++) begin
      if (r_idx == IDX_W'(k)) begin
        w_asm_ins[k*DATA_WIDTH +: DATA_WIDTH] = w_word;
      end
    end
  end

  // Next-state for FSM, assembly register, output register and counter.
  always_comb begin
    w_state_next     = r_state;
    w_idx_next       = r_idx;
    w_asm_next       = r_asm;
    w_blk_data_next  = r_blk_data;
    w_blk_last_next  = r_blk_last;
    w_blk_pad_next   = r_blk_pad;
    w_blk_valid_next = r_blk_valid && !w_out_fire;
    w_count_next     = r_count + CNT_WIDTH'(w_out_fire);

    unique case (r_state)
      FILL: begin
        if (w_in_fire) begin
          if (r_idx == LAST_IDX) begin
            w_blk_data_next  = w_asm_ins;
            w_blk_last_next  = in_last_i;
            w_blk_pad_next   = 1'b0;
            w_blk_valid_next = 1'b1;
            w_idx_next       = '0;
            w_asm_next       = '0;
          end else if (!in_last_i) begin
            w_asm_next = w_asm_ins;
            w_idx_next = r_idx + IDX_W'(1);
          end else if (w_slot_free) begin
            // Upper slots are already zero: assembly is cleared after every block.
            w_blk_data_next  = w_asm_ins;
            w_blk_last_next  = 1'b1;
            w_blk_pad_next   = 1'b1;
            w_blk_valid_next = 1'b1;
            w_idx_next       = '0;
            w_asm_next       = '0;
          end else begin
            w_asm_next   = w_asm_ins;
            w_state_next = FLUSH;
          end
        end
      end
      FLUSH: begin
        if (w_slot_free) begin
          w_blk_data_next  = r_asm;
          w_blk_last_next  = 1'b1;
          w_blk_pad_next   = 1'b1;
          w_blk_valid_next = 1'b1;
          w_idx_next       = '0;
          w_asm_next       = '0;
          w_state_next     = FILL;
        end
      end
      default: w_state_next = FILL;
    endcase
  end

  // State registers with synchronous reset / soft clear.
  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) begin
      r_state     <= FILL;
      r_idx       <= '0;
      r_asm       <= '0;
      r_blk_data  <= '0;
      r_blk_last  <= 1'b0;
      r_blk_pad   <= 1'b0;
      r_blk_valid <= 1'b0;
      r_count     <= '0;
    end else begin
      r_state     <= w_state_next;
      r_idx       <= w_idx_next;
      r_asm       <= w_asm_next;
      r_blk_data  <= w_blk_data_next;
      r_blk_last  <= w_blk_last_next;
      r_blk_pad   <= w_blk_pad_next;
      r_blk_valid <= w_blk_valid_next;
      r_count     <= w_count_next;
    end
  end

  assign blk_data_o  = r_blk_data;
  assign blk_last_o  = r_blk_last;
  assign blk_pad_o   = r_blk_pad;
  assign blk_valid_o = r_blk_valid;
  assign blk_count_o = r_count;
  assign busy_o      = (r_idx != '0) || (r_state == FLUSH) || r_blk_valid;

endmodule

// File: tb/tb_aes_block_packer.sv
// Self-checking bench for aes_block_packer: directed cases plus randomized traffic scored
// against a queue-based model of the packing rules.
module tb_aes_block_packer;

  localparam int WORDS = 4;

  logic         clk_i = 1'b0;
  logic         rst_i = 1'b1;
  logic         clear_i = 1'b0;
  logic [31:0]  in_data_i = '0;
  logic         in_last_i = 1'b0;
  logic         in_valid_i = 1'b0;
  logic         in_ready_o;
  logic [127:0] blk_data_o;
  logic         blk_last_o;
  logic         blk_pad_o;
  logic         blk_valid_o;
  logic         blk_ready_i = 1'b0;
  logic [15:0]  blk_count_o;
  logic         busy_o;

  aes_block_packer dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .clear_i     (clear_i),
    .in_data_i   (in_data_i),
    .in_last_i   (in_last_i),
    .in_valid_i  (in_valid_i),
    .in_ready_o  (in_ready_o),
    .blk_data_o  (blk_data_o),
    .blk_last_o  (blk_last_o),
    .blk_pad_o   (blk_pad_o),
    .blk_valid_o (blk_valid_o),
    .blk_ready_i (blk_ready_i),
    .blk_count_o (blk_count_o),
    .busy_o      (busy_o)
  );

  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] sw(input logic [31:0] d);
`ifdef AES_PACK_BYTESWAP_EN
    return {d[7:0], d[15:8], d[23:16], d[31:24]};
`else
    return d;
`endif
  endfunction

  typedef struct {
    logic [127:0] data;
    logic         last;
    logic         pad;
  } blk_t;

  // Model: words accepted toward the current block, blocks formed but not yet handed off.
  logic [31:0]  partial[$];
  blk_t         exp_q[$];
  logic [15:0]  model_count = '0;
  logic         mon_en = 1'b0;
  logic         allow_gap = 1'b0;
  logic         prev_hold = 1'b0;
  logic [128:0] prev_out = '0;
  logic [127:0] last_data = '0;
  logic         last_pad = 1'b0;

  always @(negedge clk_i) begin
    if (mon_en) begin
      check("busy", 128'(busy_o), 128'((partial.size() != 0) || (exp_q.size() != 0)));
      check("count", 128'(blk_count_o), 128'(model_count));
      if (blk_valid_o && exp_q.size() == 0) check("spurious_valid", 128'(blk_valid_o), 128'(0));
      if (!blk_valid_o && exp_q.size() != 0 && !allow_gap)
        check("late_block", 128'(blk_valid_o), 128'(1));
      if (prev_hold) check("stable_out", {blk_valid_o, blk_data_o}, prev_out);
      if (rst_i || clear_i) check("ready_in_clear", 128'(in_ready_o), 128'(0));
      allow_gap = 1'b0;
      if (rst_i || clear_i) begin
        partial.delete();
        exp_q.delete();
        model_count = '0;
      end else begin
        if (blk_valid_o && blk_ready_i) begin
          if (exp_q.size() == 0) begin
            check("unexpected_block", 128'(1), 128'(0));
          end else begin
            check("blk_data", blk_data_o, exp_q[0].data);
            check("blk_last", 128'(blk_last_o), 128'(exp_q[0].last));
            check("blk_pad", 128'(blk_pad_o), 128'(exp_q[0].pad));
            void'(exp_q.pop_front());
          end
          last_data   = blk_data_o;
          last_pad    = blk_pad_o;
          model_count = model_count + 16'd1;
          allow_gap   = (exp_q.size() != 0);
        end
        if (in_valid_i && in_ready_o) begin
          partial.push_back(sw(in_data_i));
          if (partial.size() == WORDS || in_last_i) begin
            blk_t b;
            b.data = '0;
            foreach (partial[k]) b.data[k*32 +: 32] = partial[k];
            b.last = in_last_i;
            b.pad  = (partial.size() < WORDS);
            exp_q.push_back(b);
            partial.delete();
            allow_gap = 1'b1;
          end
        end
      end
      prev_hold = blk_valid_o && !blk_ready_i && !rst_i && !clear_i;
      prev_out  = {blk_valid_o, blk_data_o};
    end
  end

  task automatic push(input logic [31:0] d, input logic l);
    int t = 0;
    in_data_i  = d;
    in_last_i  = l;
    in_valid_i = 1'b1;
    @(negedge clk_i);
    while (!in_ready_o && t < 200) begin
      @(negedge clk_i);
      t++;
    end
    if (t >= 200) check("push_timeout", 128'(0), 128'(1));
    @(posedge clk_i);
    #1;
    in_valid_i = 1'b0;
    in_last_i  = 1'b0;
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk_i);
    #1;
  endtask

  logic rnd_ready = 1'b0;
  always @(posedge clk_i) begin
    if (rnd_ready) begin
      #1;
      blk_ready_i = ($urandom_range(0, 3) != 0);
    end
  end

  initial begin
    @(posedge clk_i);
    #1;
    mon_en = 1'b1;
    cycles(2);
    check("reset_busy", 128'(busy_o), 128'(0));
    check("reset_valid", 128'(blk_valid_o), 128'(0));
    check("reset_data", blk_data_o, 128'(0));
    rst_i = 1'b0;
    #1;
    check("ready_after_reset", 128'(in_ready_o), 128'(1));

    // Full block, no padding.
    blk_ready_i = 1'b1;
    push(32'h03020100, 1'b0);
    push(32'h07060504, 1'b0);
    push(32'h0B0A0908, 1'b0);
    push(32'h0F0E0D0C, 1'b1);
    check("t1_valid", 128'(blk_valid_o), 128'(1));
    check("t1_data", blk_data_o,
          {sw(32'h0F0E0D0C), sw(32'h0B0A0908), sw(32'h07060504), sw(32'h03020100)});
    check("t1_last", 128'(blk_last_o), 128'(1));
    check("t1_pad", 128'(blk_pad_o), 128'(0));
    cycles(1);
    check("t1_count", 128'(blk_count_o), 128'(1));

    // Short block, padded.
    push(32'h11111111, 1'b0);
    push(32'h22222222, 1'b1);
    check("t2_data", blk_data_o, {64'h0, sw(32'h22222222), sw(32'h11111111)});
    check("t2_pad", 128'(blk_pad_o), 128'(1));
    check("t2_last", 128'(blk_last_o), 128'(1));
    cycles(1);

    // Eight words with the output stalled.
    blk_ready_i = 1'b0;
    fork
      for (int i = 0; i < 8; i++) push(32'hA0000000 + 32'(i), (i == 7));
      begin
        cycles(9);
        check("t3_stall_ready", 128'(in_ready_o), 128'(0));
        check("t3_stall_valid", 128'(in_valid_i), 128'(1));
        blk_ready_i = 1'b1;
      end
    join
    cycles(3);
    check("t3_count", 128'(blk_count_o), 128'(4));
    check("t3_idle", 128'(busy_o), 128'(0));

    // FLUSH while output is held.
    blk_ready_i = 1'b0;
    for (int i = 0; i < 4; i++) push(32'hB0000000 + 32'(i), 1'b0);
    push(32'hDEADBEEF, 1'b1);
    cycles(1);
    check("t4_flush_ready", 128'(in_ready_o), 128'(0));
    check("t4_flush_busy", 128'(busy_o), 128'(1));
    blk_ready_i = 1'b1;
    cycles(3);
    check("t4_data", last_data, {96'h0, sw(32'hDEADBEEF)});
    check("t4_pad", 128'(last_pad), 128'(1));
    check("t4_count", 128'(blk_count_o), 128'(6));

    // Soft clear mid-assembly.
    push(32'hC0C0C0C0, 1'b0);
    push(32'hC1C1C1C1, 1'b0);
    clear_i = 1'b1;
    cycles(1);
    clear_i = 1'b0;
    #1;
    check("t5_busy", 128'(busy_o), 128'(0));
    check("t5_count", 128'(blk_count_o), 128'(0));
    check("t5_valid", 128'(blk_valid_o), 128'(0));
    push(32'h33333333, 1'b0);
    push(32'h44444444, 1'b0);
    push(32'h55555555, 1'b0);
    push(32'h66666666, 1'b1);
    cycles(2);
    check("t5_data", last_data,
          {sw(32'h66666666), sw(32'h55555555), sw(32'h44444444), sw(32'h33333333)});
    check("t5_count2", 128'(blk_count_o), 128'(1));

    // Randomized traffic with random back-pressure.
    rnd_ready = 1'b1;
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 2) == 0) cycles($urandom_range(1, 2));
      push($urandom, ($urandom_range(0, 4) == 0));
    end
    push($urandom, 1'b1);
    rnd_ready = 1'b0;
    #1;
    blk_ready_i = 1'b1;
    begin
      int t = 0;
      while (busy_o && t < 50) begin
        cycles(1);
        t++;
      end
      check("drain_idle", 128'(busy_o), 128'(0));
    end
    check("drain_queue", 128'(exp_q.size()), 128'(0));
    cycles(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
